// File: rtl/prv32_div_seq_pkg.sv
// Shared encodings for the RV32M sequential divider: op codes, FSM states, ALU function.
package prv32_div_seq_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned ALU_FN_W = 4;
  localparam int unsigned OP_W     = 2;

  // ALU subtract function code, shared with the EX-stage ALU decoder
  localparam logic [ALU_FN_W-1:0] ALU_SUB = 4'b1000;

  localparam logic [OP_W-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [OP_W-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [OP_W-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [OP_W-1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIVSEQ_IDLE = 2'd0,
    DIVSEQ_ITER = 2'd1,
    DIVSEQ_FIX  = 2'd2
  } divseq_state_t;

endpackage

// File: rtl/prv32_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32 restoring-division steps on the shared EX-stage ALU.
module prv32_div_seq
  import prv32_div_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     result,
  output logic                alu_own,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [ALU_FN_W-1:0] alu_fn,
  input  logic [XLEN-1:0]     alu_r,
  input  logic                alu_cf
);

  divseq_state_t   state, state_n;
  logic [XLEN-1:0]  dvd, dvd_n;
  logic [XLEN-1:0]  dvs, dvs_n;
  logic [XLEN-1:0]  rem, rem_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             op_rem, op_rem_n;
  logic             busy_n, done_n, alu_own_n;
  logic [XLEN-1:0]  result_n;

  logic [XLEN-1:0]  sh;
  logic             take;
  logic             is_signed;
  logic [XLEN-1:0]  rs1_abs, rs2_abs;

  assign sh   = {rem[XLEN-2:0], dvd[XLEN-1]};
  // rem[31] set means the shifted partial remainder overflowed 32 bits and always exceeds dvs
  assign take = rem[XLEN-1] | alu_cf;

  assign is_signed = ~op[0];
  assign rs1_abs   = (is_signed & rs1[XLEN-1]) ? (~rs1 + 32'd1) : rs1;
  assign rs2_abs   = (is_signed & rs2[XLEN-1]) ? (~rs2 + 32'd1) : rs2;

  // ALU operands depend only on registered state, never on alu_r
  assign alu_a  = (state == DIVSEQ_ITER) ? sh      : '0;
  assign alu_b  = (state == DIVSEQ_ITER) ? dvs     : '0;
  assign alu_fn = (state == DIVSEQ_ITER) ? ALU_SUB : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIVSEQ_IDLE;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      op_rem  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      alu_own <= 1'b0;
    end else begin
      state   <= state_n;
      dvd     <= dvd_n;
      dvs     <= dvs_n;
      rem     <= rem_n;
      cnt     <= cnt_n;
      neg_q   <= neg_q_n;
      neg_r   <= neg_r_n;
      op_rem  <= op_rem_n;
      busy    <= busy_n;
      done    <= done_n;
      result  <= result_n;
      alu_own <= alu_own_n;
    end
  end

  always_comb begin
    state_n   = state;
    dvd_n     = dvd;
    dvs_n     = dvs;
    rem_n     = rem;
    cnt_n     = cnt;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    op_rem_n  = op_rem;
    busy_n    = busy;
    done_n    = 1'b0;
    result_n  = result;
    alu_own_n = 1'b0;

    unique case (state)
      DIVSEQ_IDLE: begin
        if (start) begin
          if (rs2 == '0) begin
            // divide by zero resolves without touching the ALU
            done_n   = 1'b1;
            result_n = op[1] ? rs1 : '1;
          end else begin
            dvd_n     = rs1_abs;
            dvs_n     = rs2_abs;
            neg_q_n   = is_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_r_n   = is_signed & rs1[XLEN-1];
            op_rem_n  = op[1];
            rem_n     = '0;
            cnt_n     = CNT_W'(XLEN - 1);
            busy_n    = 1'b1;
            alu_own_n = 1'b1;
            state_n   = DIVSEQ_ITER;
          end
        end
      end
      DIVSEQ_ITER: begin
        rem_n = take ? alu_r : sh;
        dvd_n = {dvd[XLEN-2:0], take};
        if (cnt == '0) begin
          state_n = DIVSEQ_FIX;
        end else begin
          cnt_n     = cnt - CNT_W'(1);
          alu_own_n = 1'b1;
        end
      end
      DIVSEQ_FIX: begin
        result_n = op_rem ? (neg_r ? (~rem + 32'd1) : rem)
                          : (neg_q ? (~dvd + 32'd1) : dvd);
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = DIVSEQ_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = DIVSEQ_IDLE;
      end
    endcase

    if (flush) begin
      state_n   = DIVSEQ_IDLE;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      alu_own_n = 1'b0;
      result_n  = result;
    end
  end

endmodule

// File: tb/tb_prv32_div_seq.sv
// Directed bench for prv32_div_seq with a behavioural subtract-only ALU beside it.
module tb_prv32_div_seq;
  import prv32_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done, alu_own;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic        alu_cf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // EX-stage ALU stand-in: subtract with carry meaning no borrow
  assign alu_r  = alu_a - alu_b;
  assign alu_cf = (alu_a >= alu_b);

  prv32_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_r(alu_r), .alu_cf(alu_cf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of the done cycle (or after the bound)
  task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_own, input int junk_at);
    int lat = 0;
    int own = 0;
    int bsy = 0;
    logic busy_at_done = 1'b1;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == junk_at) begin
        start = 1'b1; op = DIV_OP_DIVU; rs1 = 32'd1234; rs2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (alu_own) own++;
      if (busy) bsy++;
      if (done) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/alu_own_cycles"}, own, exp_own);
    chk({tag, "/busy_cycles"}, bsy, exp_lat - 1);
    chk({tag, "/busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
    chk({tag, "/result"}, result, exp_res);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/result", result, 32'd0);
    chk("rst/alu_own", {31'd0, alu_own}, 32'd0);
    chk("rst/alu_a", alu_a, 32'd0);
    chk("rst/alu_b", alu_b, 32'd0);
    chk("rst/alu_fn", {28'd0, alu_fn}, 32'd0);

    run_div("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 32, 0);
    @(negedge clk);
    chk("divu_100_7/done_pulse", {31'd0, done}, 32'd0);
    chk("divu_100_7/result_hold", result, 32'd14);
    chk("idle/alu_a", alu_a, 32'd0);

    run_div("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 32, 0);
    run_div("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 32, 0);
    run_div("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 32, 0);
    run_div("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 32, 0);
    run_div("divu_5_0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    run_div("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    run_div("div_m3_0", DIV_OP_DIV, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    run_div("divu_shovf", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 32, 0);
    run_div("remu_shovf", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, 32, 0);
    run_div("remu_big", DIV_OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34, 32, 0);

    // start while busy must be ignored
    run_div("ign_start", DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 32, 5);
    @(negedge clk);
    chk("ign_start/no_relaunch", {31'd0, busy}, 32'd0);

    // back-to-back: second start issued in the first done cycle
    run_div("b2b_a", DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, 34, 32, 0);
    run_div("b2b_b", DIV_OP_REMU, 32'd50, 32'd7, 32'd1, 34, 32, 0);

    // flush at T+10
    @(negedge clk);
    op = DIV_OP_DIVU; rs1 = 32'd999; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush/busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush/busy_after", {31'd0, busy}, 32'd0);
    chk("flush/alu_own_after", {31'd0, alu_own}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("flush/no_done", dcount, 32'd0);
    chk("flush/result_hold", result, 32'd1);

    // reset mid-operation
    op = DIV_OP_DIVU; rs1 = 32'd999; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/busy", {31'd0, busy}, 32'd0);
    chk("midrst/result", result, 32'd0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("midrst/no_done", dcount, 32'd0);

    run_div("div_m100_7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
